buster_shot_ctrl: RTL and testbench

- Player-side projectile manager: the producer end of the shot/hit interface consumed by the enemy controllers.
- Owns two shot slots. Spawns a shot on a fire press and moves it horizontally each frame.
- Publishes per-slot position and an active flag (is_shot_1/2), which the enemy controllers compare against their own x positions.
- Retires a shot when an enemy reports kill, or when the shot leaves the screen.

---
 rtl/buster_pkg.sv | 26 ++
 rtl/buster_shot_ctrl_slot.sv | 92 +++++++++
 rtl/buster_shot_ctrl.sv | 138 +++++++++++++
 tb/tb_buster_shot_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buster_pkg.sv
// Shared types and constants for the player shot manager.
// Slot states, hitbox/muzzle/charge constants and small saturating helpers.
package buster_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY_R = 2'd1,
    FLY_L = 2'd2
  } slot_state_t;

  localparam int HITBOX_W      = 18;
  localparam int MUZZLE_DX     = 31;
  localparam int CHARGE_THRESH = 32;

  // Positions are 10-bit screen coordinates; saturate rather than wrap.
  function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  function automatic logic overlaps(input logic [9:0] x, input logic [9:0] ex);
    return ({1'b0, x} >= {1'b0, ex}) && ({1'b0, x} <= ({1'b0, ex} + 11'(HITBOX_W)));
  endfunction

endpackage

// File: rtl/buster_shot_ctrl_slot.sv
// One shot slot: state, position, per-frame move and screen-edge retire.
//   state | meaning
//   IDLE  | slot free, x/y hold last values
//   FLY_R | shot moving right
//   FLY_L | shot moving left
module buster_slot
  import buster_pkg::*;
#(
  parameter int SHOT_SPEED = 6,
  parameter int SCREEN_MAX = 639,
  parameter int SHOT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_spawn,
  input  logic       i_spawn_left,
  input  logic       i_spawn_fast,
  input  logic [9:0] i_spawn_x,
  input  logic [9:0] i_spawn_y,
  input  logic       i_hit,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_active_nx,
  output logic       o_fast
);

  localparam logic [9:0] STEP_N = 10'(SHOT_SPEED);
  localparam logic [9:0] STEP_F = 10'(2 * SHOT_SPEED);
  localparam logic [9:0] RMAX_N = 10'(SCREEN_MAX - SHOT_SPEED - SHOT_W);
  localparam logic [9:0] RMAX_F = 10'(SCREEN_MAX - 2 * SHOT_SPEED - SHOT_W);

  slot_state_t r_state, w_state_nx;
  logic [9:0]  r_x, r_y, w_x_nx, w_y_nx;
  logic [9:0]  w_step, w_rmax;
  logic        r_fast, w_fast_nx;

  assign w_step = r_fast ? STEP_F : STEP_N;
  assign w_rmax = r_fast ? RMAX_F : RMAX_N;

  // Edge checks run before the move so x never leaves 0..SCREEN_MAX.
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_fast_nx  = r_fast;
    if (i_hit) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_spawn) begin
            w_state_nx = i_spawn_left ? FLY_L : FLY_R;
            w_x_nx     = i_spawn_x;
            w_y_nx     = i_spawn_y;
            w_fast_nx  = i_spawn_fast;
          end
        end
        FLY_R: begin
          if (r_x > w_rmax) w_state_nx = IDLE;
          else              w_x_nx     = r_x + w_step;
        end
        FLY_L: begin
          if (r_x < w_step) w_state_nx = IDLE;
          else              w_x_nx     = r_x - w_step;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_fast  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_fast  <= w_fast_nx;
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_active    = (r_state != IDLE);
  assign o_active_nx = (w_state_nx != IDLE);
  assign o_fast      = r_fast & (r_state != IDLE);

endmodule

// File: rtl/buster_shot_ctrl.sv
// Player projectile manager: fire/kill edge detect, slot allocation, hit arbitration, cooldown.
// Optional charged shots are built when BUSTER_CHARGE_EN is defined.
module buster_shot_ctrl
  import buster_pkg::*;
#(
  parameter int SHOT_SPEED = 6,
  parameter int SCREEN_MAX = 639,
  parameter int SHOT_W     = 8,
  parameter int COOLDOWN   = 8,
  parameter int MUZZLE_DY  = 12
) (
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       fire,
  input  logic       facing_left,
  input  logic [9:0] sprite0xr,
  input  logic [9:0] sprite0yr,
  input  logic [9:0] enemy_x,
  input  logic       kill,
  output logic [9:0] sprite12xr,
  output logic [9:0] sprite12yr,
  output logic [9:0] sprite13xr,
  output logic [9:0] sprite13yr,
  output logic       is_shot_1,
  output logic       is_shot_2,
  output logic       shot_busy
`ifdef BUSTER_CHARGE_EN
  ,
  output logic       charged_1,
  output logic       charged_2
`endif
);

  localparam int CD_W = $clog2(COOLDOWN) + 1;

  logic            r_fire_q, r_kill_q, r_shot_busy;
  logic [CD_W-1:0] r_cooldown, w_cooldown_nx;
  logic            w_fire_press, w_kill_edge, w_trigger, w_fast, w_dir_ok;
  logic            w_spawn, w_spawn_1, w_spawn_2;
  logic [9:0]      w_spawn_x, w_spawn_y;
  logic            w_act_1, w_act_2, w_act_nx_1, w_act_nx_2, w_fast_1, w_fast_2;
  logic            w_cand_1, w_cand_2, w_hit_1, w_hit_2;

  assign w_fire_press = fire & ~r_fire_q;
  assign w_kill_edge  = kill & ~r_kill_q;

`ifdef BUSTER_CHARGE_EN
  logic [5:0] r_charge_cnt;
  logic       w_charge_rel;

  assign w_charge_rel = ~fire & r_fire_q & (r_charge_cnt >= 6'(CHARGE_THRESH));
  assign w_trigger    = w_fire_press | w_charge_rel;
  assign w_fast       = w_charge_rel;
  assign charged_1    = w_fast_1;
  assign charged_2    = w_fast_2;

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset)                      r_charge_cnt <= '0;
    else if (!fire)                 r_charge_cnt <= '0;
    else if (r_charge_cnt != 6'h3F) r_charge_cnt <= r_charge_cnt + 6'd1;
  end
`else
  assign w_trigger = w_fire_press;
  assign w_fast    = 1'b0;
`endif

  // Left-facing shots would start off-screen when the player hugs the left edge.
  assign w_dir_ok  = ~facing_left | (sprite0xr >= 10'(SHOT_W));
  assign w_spawn_x = facing_left ? (sprite0xr - 10'(SHOT_W)) : sat_add10(sprite0xr, 10'(MUZZLE_DX));
  assign w_spawn_y = sat_add10(sprite0yr, 10'(MUZZLE_DY));

  assign w_spawn   = w_trigger & (r_cooldown == '0) & w_dir_ok & (~w_act_1 | ~w_act_2);
  assign w_spawn_1 = w_spawn & ~w_act_1;
  assign w_spawn_2 = w_spawn & w_act_1 & ~w_act_2;

  // Charged shots pierce, so they never compete for a kill.
  assign w_cand_1 = w_act_1 & ~w_fast_1 & overlaps(sprite12xr, enemy_x);
  assign w_cand_2 = w_act_2 & ~w_fast_2 & overlaps(sprite13xr, enemy_x);
  assign w_hit_1  = w_kill_edge & w_cand_1;
  assign w_hit_2  = w_kill_edge & w_cand_2 & ~w_cand_1;

  always_comb begin
    w_cooldown_nx = r_cooldown;
    if (w_spawn)                 w_cooldown_nx = CD_W'(COOLDOWN - 1);
    else if (r_cooldown != '0)   w_cooldown_nx = r_cooldown - CD_W'(1);
  end

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      r_fire_q    <= 1'b0;
      r_kill_q    <= 1'b0;
      r_cooldown  <= '0;
      r_shot_busy <= 1'b0;
    end else begin
      r_fire_q    <= fire;
      r_kill_q    <= kill;
      r_cooldown  <= w_cooldown_nx;
      r_shot_busy <= (w_act_nx_1 & w_act_nx_2) | (w_cooldown_nx != '0);
    end
  end

  buster_slot #(.SHOT_SPEED(SHOT_SPEED), .SCREEN_MAX(SCREEN_MAX), .SHOT_W(SHOT_W)) u_slot_1 (
    .clk          (frame_clk),
    .rst          (reset),
    .i_spawn      (w_spawn_1),
    .i_spawn_left (facing_left),
    .i_spawn_fast (w_fast),
    .i_spawn_x    (w_spawn_x),
    .i_spawn_y    (w_spawn_y),
    .i_hit        (w_hit_1),
    .o_x          (sprite12xr),
    .o_y          (sprite12yr),
    .o_active     (w_act_1),
    .o_active_nx  (w_act_nx_1),
    .o_fast       (w_fast_1)
  );

  buster_slot #(.SHOT_SPEED(SHOT_SPEED), .SCREEN_MAX(SCREEN_MAX), .SHOT_W(SHOT_W)) u_slot_2 (
    .clk          (frame_clk),
    .rst          (reset),
    .i_spawn      (w_spawn_2),
    .i_spawn_left (facing_left),
    .i_spawn_fast (w_fast),
    .i_spawn_x    (w_spawn_x),
    .i_spawn_y    (w_spawn_y),
    .i_hit        (w_hit_2),
    .o_x          (sprite13xr),
    .o_y          (sprite13yr),
    .o_active     (w_act_2),
    .o_active_nx  (w_act_nx_2),
    .o_fast       (w_fast_2)
  );

  assign is_shot_1 = w_act_1;
  assign is_shot_2 = w_act_2;
  assign shot_busy = r_shot_busy;

endmodule

// File: tb/tb_buster_shot_ctrl.sv
// Self-checking bench for buster_shot_ctrl: directed scenarios then randomized frames vs a behavioural model.
module tb_buster_shot_ctrl;

  localparam int SPEED = 6;
  localparam int SCR_MAX = 639;
  localparam int SW = 8;
  localparam int CD = 8;
  localparam int MDY = 12;

  logic       frame_clk = 1'b0;
  logic       reset, fire, facing_left, kill;
  logic [9:0] sprite0xr, sprite0yr, enemy_x;
  logic [9:0] sprite12xr, sprite12yr, sprite13xr, sprite13yr;
  logic       is_shot_1, is_shot_2, shot_busy;
`ifdef BUSTER_CHARGE_EN
  logic       charged_1, charged_2;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model: two shots as plain integers.
  int m_act[2], m_x[2], m_y[2], m_dir[2];
  int m_cd, m_fire_q, m_kill_q;

  always #5 frame_clk = ~frame_clk;

  buster_shot_ctrl dut (
    .frame_clk   (frame_clk),
    .reset       (reset),
    .fire        (fire),
    .facing_left (facing_left),
    .sprite0xr   (sprite0xr),
    .sprite0yr   (sprite0yr),
    .enemy_x     (enemy_x),
    .kill        (kill),
    .sprite12xr  (sprite12xr),
    .sprite12yr  (sprite12yr),
    .sprite13xr  (sprite13xr),
    .sprite13yr  (sprite13yr),
    .is_shot_1   (is_shot_1),
    .is_shot_2   (is_shot_2),
    .shot_busy   (shot_busy)
`ifdef BUSTER_CHARGE_EN
    ,
    .charged_1   (charged_1),
    .charged_2   (charged_2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 2; s++) begin
      m_act[s] = 0; m_x[s] = 0; m_y[s] = 0; m_dir[s] = 1;
    end
    m_cd = 0; m_fire_q = 0; m_kill_q = 0;
  endtask

  task automatic m_step(input int f, input int l, input int x0, input int y0, input int ex, input int k);
    int hit, sp;
    bit press, kedge;
    press = (f != 0) && (m_fire_q == 0);
    kedge = (k != 0) && (m_kill_q == 0);
    hit = -1;
    if (kedge)
      for (int s = 0; s < 2; s++)
        if (hit < 0 && m_act[s] != 0 && ex <= m_x[s] && m_x[s] <= ex + 18) hit = s;
    sp = -1;
    if (press && m_cd == 0 && (l == 0 || x0 >= SW))
      for (int s = 0; s < 2; s++)
        if (sp < 0 && m_act[s] == 0) sp = s;
    for (int s = 0; s < 2; s++) begin
      if (s == hit) m_act[s] = 0;
      else if (m_act[s] != 0) begin
        if (m_dir[s] > 0) begin
          if (m_x[s] + SPEED + SW > SCR_MAX) m_act[s] = 0;
          else m_x[s] += SPEED;
        end else begin
          if (m_x[s] - SPEED < 0) m_act[s] = 0;
          else m_x[s] -= SPEED;
        end
      end else if (s == sp) begin
        m_act[s] = 1;
        m_dir[s] = (l != 0) ? -1 : 1;
        m_x[s]   = (l != 0) ? x0 - SW : x0 + 31;
        m_y[s]   = y0 + MDY;
      end
    end
    m_cd = (sp >= 0) ? CD - 1 : ((m_cd > 0) ? m_cd - 1 : 0);
    m_fire_q = f;
    m_kill_q = k;
  endtask

  task automatic check_all();
    chk("is_shot_1", is_shot_1, m_act[0]);
    chk("is_shot_2", is_shot_2, m_act[1]);
    chk("slot1_x", sprite12xr, m_x[0]);
    chk("slot1_y", sprite12yr, m_y[0]);
    chk("slot2_x", sprite13xr, m_x[1]);
    chk("slot2_y", sprite13yr, m_y[1]);
    chk("shot_busy", shot_busy, ((m_act[0] != 0 && m_act[1] != 0) || m_cd > 0) ? 1 : 0);
  endtask

  task automatic tick(input int f, input int l, input int x0, input int y0, input int ex, input int k);
    fire = f[0]; facing_left = l[0];
    sprite0xr = x0[9:0]; sprite0yr = y0[9:0]; enemy_x = ex[9:0]; kill = k[0];
    @(posedge frame_clk);
    m_step(f, l, x0, y0, ex, k);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    fire = 1'b0; kill = 1'b0;
    reset = 1'b1;
    #1;
    m_reset();
    reset = 1'b0;
  endtask

  initial begin
    int ex_i, s_pick, n;
    reset = 1'b1; fire = 1'b0; facing_left = 1'b0; kill = 1'b0;
    sprite0xr = '0; sprite0yr = '0; enemy_x = '0;
    m_reset();
    #7;
    chk("rst_is_shot_1", is_shot_1, 0);
    chk("rst_is_shot_2", is_shot_2, 0);
    chk("rst_x1", sprite12xr, 0);
    chk("rst_busy", shot_busy, 0);
    reset = 1'b0;

    // Fire right, fly to the right edge.
    tick(1, 0, 100, 380, 0, 0);
    chk("fire_r_x", sprite12xr, 131);
    chk("fire_r_y", sprite12yr, 392);
    tick(0, 0, 100, 380, 0, 0);
    chk("fire_r_move", sprite12xr, 137);
    n = 0;
    while (m_act[0] != 0 && n < 200) begin
      tick(0, 0, 100, 380, 0, 0);
      n++;
    end
    chk("right_retire_bound", (n < 200) ? 1 : 0, 1);
    chk("right_retire_x", sprite12xr, 629);

    // Async reset mid-flight.
    do_reset();
    tick(1, 0, 169, 50, 0, 0);
    chk("rmf_x", sprite12xr, 200);
    tick(0, 0, 169, 50, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rmf_active", is_shot_1, 0);
    chk("rmf_x0", sprite12xr, 0);
    m_reset();
    #1 reset = 1'b0;

    // Left edge, no wrap.
    tick(1, 1, 20, 100, 0, 0);
    chk("left_x12", sprite12xr, 12);
    tick(0, 1, 20, 100, 0, 0);
    chk("left_x6", sprite12xr, 6);
    tick(0, 1, 20, 100, 0, 0);
    chk("left_x0", sprite12xr, 0);
    chk("left_alive0", is_shot_1, 1);
    tick(0, 1, 20, 100, 0, 0);
    chk("left_retired", is_shot_1, 0);
    chk("left_hold_x", sprite12xr, 0);

    // Left fire too close to the left edge: no spawn.
    do_reset();
    tick(1, 1, 5, 100, 0, 0);
    chk("left_blocked", is_shot_1, 0);
    chk("left_blocked_busy", shot_busy, 0);

    // Double shot and cooldown.
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      tick((c == 0 || c == 3 || c == 9 || c == 18) ? 1 : 0, 0, 100, 50, 0, 0);
      if (c == 0) chk("dbl_c0_slot1", is_shot_1, 1);
      if (c == 3) chk("dbl_c3_ignored", is_shot_2, 0);
      if (c == 9) chk("dbl_c9_slot2", is_shot_2, 1);
    end
    chk("dbl_drop_busy", shot_busy, 1);

    // Hit arbitration.
    do_reset();
    tick(1, 0, 221, 200, 0, 0);
    for (int c = 1; c < 8; c++) tick(0, 0, 221, 200, 0, 0);
    tick(1, 0, 279, 200, 0, 0);
    chk("hit_pre_x1", sprite12xr, 300);
    chk("hit_pre_x2", sprite13xr, 310);
    tick(0, 0, 279, 200, 295, 1);
    chk("hit1_slot1_idle", is_shot_1, 0);
    chk("hit1_slot2_alive", is_shot_2, 1);
    tick(0, 0, 279, 200, 316, 1);
    chk("hit_held_ignored", is_shot_2, 1);
    tick(0, 0, 279, 200, 316, 0);
    tick(0, 0, 279, 200, 320, 1);
    chk("hit2_slot2_idle", is_shot_2, 0);

    // Held fire spawns once.
    do_reset();
    for (int c = 0; c < 20; c++) tick(1, 0, 100, 60, 0, 0);
    tick(0, 0, 100, 60, 0, 0);
    chk("held_slot1", is_shot_1, 1);
    chk("held_slot2", is_shot_2, 0);

    // Randomized frames.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_act[0] != 0 || m_act[1] != 0) begin
        s_pick = (m_act[0] != 0) ? 0 : 1;
        if (m_act[1] != 0 && $urandom_range(0, 1) == 1) s_pick = 1;
        ex_i = m_x[s_pick] - int'($urandom_range(0, 25));
        if (ex_i < 0) ex_i = 0;
      end else begin
        ex_i = int'($urandom_range(0, 639));
      end
      tick(($urandom_range(0, 2) == 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 600)),
           int'($urandom_range(0, 460)),
           ex_i,
           ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
